// File: rtl/io_bus_ctrl.sv
// io_bus_ctrl: memory-mapped LED, synchronized switch, sticky switch-event and
// loadable timer registers in the upper half of the 9-bit CPU address space.
module io_bus_ctrl #(
    parameter int unsigned PRESC = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  mem_cmd,
    input  logic [8:0]  mem_addr,
    input  logic [15:0] din,
    input  logic [7:0]  sw,
    output logic [15:0] dout,
    output logic        dout_en,
    output logic [7:0]  led
);
    localparam logic [1:0]  MREAD  = 2'b01;
    localparam logic [1:0]  MWRITE = 2'b10;
    localparam logic [15:0] PMAX   = 16'(PRESC - 1);

    typedef enum logic [1:0] {WARM0, WARM1, RUN} state_t;

    state_t      state, state_nxt;
    logic [7:0]  s1, sw_sync, sw_prev, ev, rise;
    logic [15:0] timer, presc;
    logic        rd, wr, armed;
    logic        sel_led, sel_sw, sel_tmr, sel_ev;

    assign rd      = mem_cmd == MREAD;
    assign wr      = mem_cmd == MWRITE;
    assign sel_led = mem_addr == 9'h100;
    assign sel_sw  = mem_addr == 9'h140;
    assign sel_tmr = mem_addr == 9'h180;
    assign sel_ev  = mem_addr == 9'h1C0;
    assign armed   = state == RUN;
    assign rise    = sw_sync & ~sw_prev;

    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= WARM0;
        else        state <= state_nxt;

    always_comb begin
        state_nxt = RUN;
        if (state == WARM0) state_nxt = WARM1;
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) led <= '0;
        else if (wr && sel_led) led <= din[7:0];

    // During warm-up sw_prev shadows the incoming level, so switches already
    // high at reset release never look like rising edges once armed.
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            s1      <= '0;
            sw_sync <= '0;
            sw_prev <= '0;
        end else begin
            s1      <= sw;
            sw_sync <= s1;
            sw_prev <= armed ? sw_sync : s1;
        end

    always_ff @(posedge clk or negedge reset)
        if (!reset) ev <= '0;
        else        ev <= (ev & ~((wr && sel_ev) ? din[7:0] : 8'h00)) | (rise & {8{armed}});

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            timer <= '0;
            presc <= '0;
        end else if (wr && sel_tmr) begin
            timer <= din;
            presc <= '0;
        end else if (presc == PMAX) begin
            timer <= timer + 16'd1;
            presc <= '0;
        end else begin
            presc <= presc + 16'd1;
        end

    always_comb begin
        dout_en = rd & (sel_led | sel_sw | sel_tmr | sel_ev);
        dout    = !dout_en ? 16'h0000 :
                  sel_led  ? {8'h00, led} :
                  sel_sw   ? {8'h00, sw_sync} :
                  sel_tmr  ? timer : {8'h00, ev};
    end
endmodule

// File: tb/tb_io_bus_ctrl.sv
// tb_io_bus_ctrl: directed vectors against a PRESC=1 and a PRESC=3 instance sharing one bus.
module tb_io_bus_ctrl;
    logic        clk = 1'b0, reset = 1'b1;
    logic [1:0]  mem_cmd = 2'b00;
    logic [8:0]  mem_addr = '0;
    logic [15:0] din = '0;
    logic [7:0]  sw = '0;
    logic [15:0] dout1, dout3;
    logic        en1, en3;
    logic [7:0]  led1, led3;
    int          vectors = 0, errs = 0;

    io_bus_ctrl #(.PRESC(1)) dut1 (
        .clk(clk), .reset(reset), .mem_cmd(mem_cmd), .mem_addr(mem_addr), .din(din),
        .sw(sw), .dout(dout1), .dout_en(en1), .led(led1)
    );
    io_bus_ctrl #(.PRESC(3)) dut3 (
        .clk(clk), .reset(reset), .mem_cmd(mem_cmd), .mem_addr(mem_addr), .din(din),
        .sw(sw), .dout(dout3), .dout_en(en3), .led(led3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus(input logic [1:0] c, input logic [8:0] a, input logic [15:0] d);
        mem_cmd = c; mem_addr = a; din = d;
        #1;
    endtask

    initial begin
        #1 reset = 1'b0;
        sw = 8'hFF; step(1);
        sw = 8'h01; step(1);
        chk("rst_led", {8'h00, led1}, 16'h0000);
        chk("rst_en", {15'h0, en1}, 16'h0000);
        chk("rst_dout", dout1, 16'h0000);
        reset = 1'b1;
        step(5);
        bus(2'b01, 9'h180, 16'h0);
        chk("tmr_p1_5", dout1, 16'h0005);
        chk("tmr_en", {15'h0, en1}, 16'h0001);
        chk("tmr_p3_5", dout3, 16'h0001);
        bus(2'b01, 9'h1C0, 16'h0);
        chk("ev_noboot", dout1, 16'h0000);
        bus(2'b10, 9'h100, 16'hABCD); step(1);
        bus(2'b01, 9'h100, 16'h0);
        chk("led_out", {8'h00, led1}, 16'h00CD);
        chk("led_rd", dout1, 16'h00CD);
        chk("led_en", {15'h0, en1}, 16'h0001);
        bus(2'b10, 9'h120, 16'h1111); step(1);
        chk("unmap_wr", {8'h00, led1}, 16'h00CD);
        bus(2'b01, 9'h120, 16'h0);
        chk("unmap_en", {15'h0, en1}, 16'h0000);
        chk("unmap_dout", dout1, 16'h0000);
        bus(2'b01, 9'h0C0, 16'h0);
        chk("low_half_en", {15'h0, en1}, 16'h0000);
        bus(2'b00, 9'h0, 16'h0);
        sw = 8'h81; step(1);
        bus(2'b01, 9'h140, 16'h0);
        chk("sw_1edge", dout1, 16'h0001);
        step(1);
        chk("sw_2edge", dout1, 16'h0081);
        bus(2'b01, 9'h1C0, 16'h0);
        chk("ev_2edge", dout1, 16'h0000);
        step(1);
        chk("ev_3edge", dout1, 16'h0080);
        sw = 8'h01; step(3);
        sw = 8'h81; step(2);
        bus(2'b10, 9'h1C0, 16'h0080); step(1);
        bus(2'b01, 9'h1C0, 16'h0);
        chk("ev_set_wins", dout1, 16'h0080);
        bus(2'b10, 9'h1C0, 16'h0080); step(1);
        bus(2'b01, 9'h1C0, 16'h0);
        chk("ev_clr", dout1, 16'h0000);
        sw = 8'h01; step(3);
        sw = 8'h81; step(3);
        chk("ev_reset", dout1, 16'h0080);
        bus(2'b10, 9'h180, 16'hFFFE); step(1);
        bus(2'b00, 9'h0, 16'h0); step(6);
        bus(2'b01, 9'h180, 16'h0);
        chk("tmr_wrap_p3", dout3, 16'h0000);
        chk("tmr_wrap_p1", dout1, 16'h0004);
        bus(2'b00, 9'h0, 16'h0); step(2);
        bus(2'b10, 9'h180, 16'h1234); step(1);
        bus(2'b00, 9'h0, 16'h0); step(2);
        bus(2'b01, 9'h180, 16'h0);
        chk("tmr_wr_wins", dout3, 16'h1234);
        step(1);
        chk("tmr_next_tick", dout3, 16'h1235);
        bus(2'b10, 9'h180, 16'h0042); step(4);
        bus(2'b01, 9'h180, 16'h0);
        chk("tmr_held_p1", dout1, 16'h0042);
        chk("tmr_held_p3", dout3, 16'h0042);
        bus(2'b01, 9'h1C0, 16'h0);
        chk("pre_arst_ev", dout1, 16'h0080);
        chk("pre_arst_led", {8'h00, led1}, 16'h00CD);
        #2 reset = 1'b0;
        #1;
        chk("arst_led", {8'h00, led1}, 16'h0000);
        chk("arst_ev", dout1, 16'h0000);
        bus(2'b01, 9'h100, 16'h0);
        chk("arst_led_rd", dout1, 16'h0000);
        bus(2'b00, 9'h0, 16'h0);
        step(1);
        reset = 1'b1;
        step(5);
        bus(2'b01, 9'h1C0, 16'h0);
        chk("rearm_ev", dout1, 16'h0000);
        bus(2'b01, 9'h140, 16'h0);
        chk("rearm_sw", dout1, 16'h0081);
        bus(2'b01, 9'h180, 16'h0);
        chk("rearm_tmr", dout1, 16'h0005);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
